util_fifo_sc_thresh: RTL and testbench
======================================

Name: util_fifo_sc_thresh

Overview:
Single-clock FIFO and the parametrised successor to the dual-clock util_fifo, for same-domain buffering in the 1553 datapaths. It adds programmable almost-full and almost-empty flags, sticky overflow and underflow error flags, and a synchronous flush. It supports standard and first-word-fall-through (FWFT) read modes and a write acknowledge. Storage is an inferred RAM with registered read.

Parameters:
FIFO_DEPTH, 256, number of words; must be a power of 2 and at least 4.
BYTE_WIDTH, 1, data width in bytes; word width is BYTE_WIDTH*8.
COUNT_WIDTH, 9, data_count width; must be at least clog2(FIFO_DEPTH)+1.
FWFT, 1, 1 selects FWFT read, 0 selects standard read.
ALMOST_FULL_THRESH, 240, wr_almost_full asserts when data_count >= this value.
ALMOST_EMPTY_THRESH, 16, rd_almost_empty asserts when data_count <= this value.
DATA_ZERO, 0, 1 forces rd_data to 0 whenever rd_valid is 0.
ACK_ENA, 1, 1 enables wr_ack; 0 ties wr_ack to 0.
RAM_TYPE, "block", synthesis RAM style attribute.

Ports:
clk  in  1  sole clock, rising edge.
rst  in  1  asynchronous reset, active-high.
flush  in  1  synchronous clear.
wr_en  in  1  write request.
wr_data  in  BYTE_WIDTH*8  write data.
wr_ack  out  1  accepted-write pulse.
wr_full  out  1  FIFO full.
wr_almost_full  out  1  count >= ALMOST_FULL_THRESH.
overflow  out  1  sticky: write attempted while full.
rd_en  in  1  read request (standard mode) or pop (FWFT mode).
rd_data  out  BYTE_WIDTH*8  read data.
rd_valid  out  1  rd_data valid.
rd_empty  out  1  no readable word.
rd_almost_empty  out  1  count <= ALMOST_EMPTY_THRESH.
underflow  out  1  sticky: read attempted while empty.
data_count  out  COUNT_WIDTH  words accepted and not yet popped.

Behaviour:
- Reset: clears all pointers and data_count to 0.
  - wr_full, wr_ack, overflow, underflow, rd_valid are 0.
  - rd_data is 0.
  - rd_empty is 1; rd_almost_empty is 1; wr_almost_full is 0.
- Reset mid-operation discards all contents immediately.
- Write acceptance: acc_w = wr_en & ~wr_full.
  - A write while full is dropped and sets overflow.
  - A simultaneous read in the same cycle does not make room for the write.
- wr_ack: when ACK_ENA=1, 1-cycle pulse on the cycle after acc_w.
- Standard mode (FWFT=0):
  - acc_r = rd_en & (data_count != 0).
  - rd_data and rd_valid (1-cycle pulse) appear 1 cycle after acc_r.
  - rd_data holds its last value otherwise, unless DATA_ZERO=1.
  - rd_empty = (data_count == 0).
- FWFT mode (FWFT=1):
  - The head word is presented on rd_data with rd_valid=1 without a request.
  - acc_r = rd_en & rd_valid pops the head word.
  - The next word is presented on the following cycle with no bubble while the RAM holds data.
  - A write into an empty FIFO sets rd_valid 2 cycles after acc_w (RAM read plus output register).
  - rd_empty = ~rd_valid.
- underflow sets on rd_en when no read is accepted.
- data_count:
  - +1 on acc_w only; -1 on acc_r only; unchanged when both occur.
  - Registered: it updates on the same edge as the pointers.
  - In FWFT mode it includes the word held in the output register.
- Flags: wr_full = (data_count == FIFO_DEPTH). Almost flags are registered and derived from the next-state count, so they align with data_count.
- Pointers: clog2(FIFO_DEPTH) bits, natural wrap-around with no special case.
- Sticky flags: overflow and underflow clear only on rst or flush.
- Flush: priority over wr_en and rd_en in that cycle.
  - Pointers, count, rd_valid, wr_ack, overflow and underflow are cleared on the next edge.
  - RAM contents are not cleared.

Test Plan:
- FIFO_DEPTH=16, FWFT=0: write 0x01..0x10 -> wr_full=1 and data_count=16 after the 16th edge; wr_ack pulses 16 times. 17th write -> dropped, overflow=1.
- Same config: read 16 times -> rd_data 0x01..0x10 in order, each 1 cycle after rd_en with rd_valid pulsed. Extra rd_en -> underflow=1, rd_empty=1.
- FWFT=1: single write 0xA5 into empty FIFO -> rd_valid=1 and rd_data=0xA5 exactly 2 cycles later. rd_en=1 -> rd_valid=0 next cycle, data_count=0.
- Thresholds 12/3, depth 16: fill to 11 -> wr_almost_full=0; 12th write -> 1. Drain to 3 -> rd_almost_empty=1.
- Simultaneous rd_en and wr_en at count 8 for 40 cycles -> data_count stays 8, data in order across pointer wrap. Same at count 16 -> write dropped, count 15.
- Flush at count 10 with overflow=1 -> next cycle data_count=0, rd_empty=1, overflow=0. Async rst asserted mid-cycle -> outputs reset without waiting for a clock edge.

Source files
------------

// File: rtl/util_fifo_sc_thresh.sv
// Single-clock FIFO with programmable almost flags, sticky error flags,
// synchronous flush and selectable standard / first-word-fall-through read.
`timescale 1ns/1ps
module util_fifo_sc_thresh #(
  parameter int    FIFO_DEPTH          = 256,
  parameter int    BYTE_WIDTH          = 1,
  parameter int    COUNT_WIDTH         = 9,
  parameter int    FWFT                = 1,
  parameter int    ALMOST_FULL_THRESH  = 240,
  parameter int    ALMOST_EMPTY_THRESH = 16,
  parameter int    DATA_ZERO           = 0,
  parameter int    ACK_ENA             = 1,
  parameter string RAM_TYPE            = "block"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [BYTE_WIDTH*8-1:0] wr_data,
  output logic                    wr_ack,
  output logic                    wr_full,
  output logic                    wr_almost_full,
  output logic                    overflow,
  input  logic                    rd_en,
  output logic [BYTE_WIDTH*8-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    rd_empty,
  output logic                    rd_almost_empty,
  output logic                    underflow,
  output logic [COUNT_WIDTH-1:0]  data_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = BYTE_WIDTH * 8;
  localparam int CW = COUNT_WIDTH;

  (* ram_style = RAM_TYPE *)
  logic [DW-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] ram_cnt;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          rv_q, rv_d;
  logic          ack_q, ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          af_q, af_d;
  logic          ae_q, ae_d;
  logic          full, acc_w, acc_r, ld;

  always_comb begin
    full  = (count_q == CW'(FIFO_DEPTH));
    acc_w = wr_en & ~full & ~flush;
    acc_r = 1'b0;
    ld    = 1'b0;
    ram_cnt = count_q;
    rv_d  = 1'b0;
    if (FWFT != 0) begin
      // the word in the output register is counted but no longer in RAM
      ram_cnt = count_q - CW'(rv_q);
      acc_r   = rd_en & rv_q & ~flush;
      ld      = (ram_cnt != '0) & (~rv_q | acc_r) & ~flush;
      rv_d    = ld | (rv_q & ~acc_r);
    end else begin
      acc_r = rd_en & (count_q != '0) & ~flush;
      ld    = acc_r;
      rv_d  = acc_r;
    end
    rdat_d   = ld ? mem[rd_ptr_q] : rdat_q;
    wr_ptr_d = wr_ptr_q + AW'(acc_w);
    rd_ptr_d = rd_ptr_q + AW'(ld);
    unique case ({acc_w, acc_r})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ack_d = (ACK_ENA != 0) & acc_w;
    ovf_d = ovf_q | (wr_en & full);
    udf_d = udf_q | (rd_en & ~acc_r);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rv_d     = 1'b0;
      ack_d    = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end
    af_d = (count_d >= CW'(ALMOST_FULL_THRESH));
    ae_d = (count_d <= CW'(ALMOST_EMPTY_THRESH));
  end

  always_ff @(posedge clk) begin
    if (acc_w) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdat_q   <= '0;
      rv_q     <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdat_q   <= rdat_d;
      rv_q     <= rv_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  assign wr_ack          = ack_q;
  assign wr_full         = full;
  assign wr_almost_full  = af_q;
  assign overflow        = ovf_q;
  assign rd_valid        = rv_q;
  assign rd_data         = ((DATA_ZERO != 0) && !rv_q) ? '0 : rdat_q;
  assign rd_empty        = (FWFT != 0) ? ~rv_q : (count_q == '0);
  assign rd_almost_empty = ae_q;
  assign underflow       = udf_q;
  assign data_count      = count_q;

endmodule

// File: tb/tb_util_fifo_sc_thresh.sv
// Directed bench: standard-mode table vectors plus FWFT, flush,
// pointer-wrap and async-reset sequences on two 16-deep instances.
`timescale 1ns/1ps
module tb_util_fifo_sc_thresh;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s_flush, s_we, s_re;
  logic [7:0] s_wd, s_rdata;
  logic       s_ack, s_full, s_af, s_ovf, s_rv, s_empty, s_ae, s_udf;
  logic [4:0] s_cnt;

  logic       f_flush, f_we, f_re;
  logic [7:0] f_wd, f_rdata;
  logic       f_ack, f_full, f_af, f_ovf, f_rv, f_empty, f_ae, f_udf;
  logic [4:0] f_cnt;

  util_fifo_sc_thresh #(
    .FIFO_DEPTH(16), .BYTE_WIDTH(1), .COUNT_WIDTH(5), .FWFT(0),
    .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(3),
    .DATA_ZERO(0), .ACK_ENA(1), .RAM_TYPE("block")
  ) u_std (
    .clk(clk), .rst(rst), .flush(s_flush),
    .wr_en(s_we), .wr_data(s_wd), .wr_ack(s_ack),
    .wr_full(s_full), .wr_almost_full(s_af), .overflow(s_ovf),
    .rd_en(s_re), .rd_data(s_rdata), .rd_valid(s_rv),
    .rd_empty(s_empty), .rd_almost_empty(s_ae),
    .underflow(s_udf), .data_count(s_cnt)
  );

  util_fifo_sc_thresh #(
    .FIFO_DEPTH(16), .BYTE_WIDTH(1), .COUNT_WIDTH(5), .FWFT(1),
    .ALMOST_FULL_THRESH(12), .ALMOST_EMPTY_THRESH(3),
    .DATA_ZERO(1), .ACK_ENA(1), .RAM_TYPE("block")
  ) u_fw (
    .clk(clk), .rst(rst), .flush(f_flush),
    .wr_en(f_we), .wr_data(f_wd), .wr_ack(f_ack),
    .wr_full(f_full), .wr_almost_full(f_af), .overflow(f_ovf),
    .rd_en(f_re), .rd_data(f_rdata), .rd_valid(f_rv),
    .rd_empty(f_empty), .rd_almost_empty(f_ae),
    .underflow(f_udf), .data_count(f_cnt)
  );

  typedef struct {
    logic       we;
    logic [7:0] wd;
    logic       re;
    logic [4:0] cnt;
    logic       full;
    logic       ack;
    logic       rv;
    logic [7:0] rd;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t tv[34];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] wd,
                              input logic re, input logic [4:0] cnt,
                              input logic full, input logic ack,
                              input logic rv, input logic [7:0] rd,
                              input logic ovf, input logic udf);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.cnt = cnt;
    v.full = full; v.ack = ack; v.rv = rv; v.rd = rd;
    v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  function automatic logic [20:0] exp_of(input vec_t v);
    return {v.cnt, v.full, v.ack, v.rv, v.rd, v.ovf, v.udf,
            v.cnt == 5'd0, v.cnt >= 5'd12, v.cnt <= 5'd3};
  endfunction

  function automatic logic [20:0] obs_std();
    return {s_cnt, s_full, s_ack, s_rv, s_rdata, s_ovf, s_udf,
            s_empty, s_af, s_ae};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    s_flush = 0; s_we = 0; s_re = 0; s_wd = '0;
    f_flush = 0; f_we = 0; f_re = 0; f_wd = '0;

    for (int k = 1; k <= 16; k++)
      tv[k-1] = mk(1, 8'(k), 0, 5'(k), k == 16, 1, 0, 8'h00, 0, 0);
    tv[16] = mk(1, 8'h11, 0, 5'd16, 1, 0, 0, 8'h00, 1, 0);
    tv[17] = mk(1, 8'h77, 1, 5'd15, 0, 0, 1, 8'h01, 1, 0);
    for (int j = 1; j <= 15; j++)
      tv[17+j] = mk(0, 8'h00, 1, 5'(15 - j), 0, 0, 1, 8'(j + 1), 1, 0);
    tv[33] = mk(0, 8'h00, 1, 5'd0, 0, 0, 0, 8'h10, 1, 1);

    repeat (2) @(posedge clk);
    #1 rst = 0;

    chk("std_reset", 32'(obs_std()),
        32'({5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
             1'b1, 1'b0, 1'b1}));
    chk("fw_reset", 32'({f_cnt, f_rv, f_empty, f_rdata, f_ae, f_af}),
        32'({5'd0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0}));

    for (int i = 0; i < 34; i++) begin
      s_we = tv[i].we; s_wd = tv[i].wd; s_re = tv[i].re;
      step();
      chk($sformatf("vec%0d", i), 32'(obs_std()), 32'(exp_of(tv[i])));
    end
    s_we = 0; s_re = 0;

    for (int i = 0; i < 10; i++) begin
      s_we = 1; s_wd = 8'h20 + 8'(i);
      step();
    end
    s_we = 0;
    chk("pre_flush", 32'({s_cnt, s_ovf}), 32'({5'd10, 1'b1}));
    s_flush = 1; s_we = 1; s_re = 1; s_wd = 8'hEE;
    step();
    s_flush = 0; s_we = 0; s_re = 0;
    chk("flush",
        32'({s_cnt, s_empty, s_ovf, s_udf, s_ack, s_rv, s_af, s_ae}),
        32'({5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));

    for (int i = 0; i < 8; i++) begin
      s_we = 1; s_wd = 8'h40 + 8'(i);
      step();
    end
    s_we = 0;
    chk("fill8", 32'(s_cnt), 32'd8);
    for (int n = 0; n < 40; n++) begin
      s_we = 1; s_re = 1; s_wd = 8'h48 + 8'(n);
      step();
      chk($sformatf("wrap%0d", n), 32'({s_cnt, s_rv, s_rdata, s_full}),
          32'({5'd8, 1'b1, 8'h40 + 8'(n), 1'b0}));
    end
    s_we = 0; s_re = 0;

    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_rst",
        32'({s_cnt, s_rv, s_empty, s_ae, s_af, s_rdata, s_ovf, s_udf}),
        32'({5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    #2 rst = 0;

    step();
    f_we = 1; f_wd = 8'hA5;
    step();
    f_we = 0;
    chk("fw_wr1", 32'({f_ack, f_rv, f_cnt, f_empty}),
        32'({1'b1, 1'b0, 5'd1, 1'b1}));
    step();
    chk("fw_wr2", 32'({f_rv, f_rdata, f_empty, f_cnt}),
        32'({1'b1, 8'hA5, 1'b0, 5'd1}));
    f_re = 1;
    step();
    f_re = 0;
    chk("fw_pop", 32'({f_rv, f_cnt, f_empty, f_rdata, f_udf}),
        32'({1'b0, 5'd0, 1'b1, 8'h00, 1'b0}));

    for (int i = 0; i < 3; i++) begin
      f_we = 1; f_wd = 8'hB0 + 8'(i);
      step();
    end
    f_we = 0;
    step();
    chk("fw_head", 32'({f_rv, f_rdata, f_cnt}),
        32'({1'b1, 8'hB0, 5'd3}));
    f_re = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i < 2)
        chk($sformatf("fw_burst%0d", i), 32'({f_rv, f_rdata, f_cnt}),
            32'({1'b1, 8'hB1 + 8'(i), 5'(2 - i)}));
      else
        chk("fw_burst2", 32'({f_rv, f_rdata, f_cnt}),
            32'({1'b0, 8'h00, 5'd0}));
    end
    step();
    f_re = 0;
    chk("fw_udf", 32'({f_udf, f_empty, f_cnt}),
        32'({1'b1, 1'b1, 5'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
